seq_detector_param: RTL and testbench
=====================================

Name: seq_detector_param

Overview:
- Parametrised serial bit-pattern detector; successor to the fixed 4-bit "1010" Moore detectors in the fsm library.
- Pattern width and pattern value are set by parameter, and pattern and overlap mode can be reloaded at runtime.
- Input bits are qualified by a valid strobe; a saturating counter records how many matches have occurred.
- Used as a generic framing/sync-word detector on single-bit serial streams.

Parameters:
- PAT_W, 4, pattern length in bits; legal range 2..32.
- DEFAULT_PAT, 4'b1010, pattern loaded at reset; PAT_W bits wide, MSB is the first bit received.
- CNT_W, 8, width of the match counter.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  in is sampled only when high
- in  input  1  serial data bit
- cfg_load  input  1  one-cycle strobe that loads cfg_pattern and cfg_overlap
- cfg_pattern  input  PAT_W  new pattern; MSB is the first bit received
- cfg_overlap  input  1  0 = non-overlapping, 1 = overlapping
- out  output  1  registered match pulse
- match_count  output  CNT_W  saturating count of matches

Behaviour:
- Single clock; reset is synchronous and active-high. Every register updates only on the rising edge of clk.
- Reset values: pattern=DEFAULT_PAT, overlap=0, hist=0, fill=0, out=0, match_count=0.
- Internal state:
  - hist[PAT_W-1:0]: history shift register.
  - fill: count of valid history bits, width $clog2(PAT_W+1), range 0..PAT_W.
  - Control FSM derived from fill: EMPTY (fill=0), FILLING (0<fill<PAT_W), ARMED (fill=PAT_W).
- Priority per cycle: rst > cfg_load > in_valid.
- cfg_load:
  - pattern<=cfg_pattern, overlap<=cfg_overlap, hist<=0, fill<=0, out<=0, match_count<=0.
  - in is ignored in that cycle, even if in_valid=1.
- Accepted bit (in_valid=1, no rst, no cfg_load):
  - hist_n={hist[PAT_W-2:0],in}; fill_n=min(fill+1,PAT_W).
  - match = (fill_n==PAT_W) && (hist_n==pattern).
  - hist<=hist_n; out<=match.
  - If match and overlap=0: fill<=0. If match and overlap=1: fill<=PAT_W. If no match: fill<=fill_n.
  - If match: match_count<=match_count+1, saturating at 2^CNT_W-1 (holds, never wraps).
- No accepted bit (in_valid=0): hist, fill and match_count hold; out<=0.
- Latency: out is high in the cycle after the clock edge that sampled the final pattern bit (Moore timing, same as the legacy detectors).
- out width: one cycle per match. It stays high over consecutive cycles only when consecutive accepted bits each complete a match (overlap=1, periodic patterns such as all-ones).
- Non-overlap: after a match, PAT_W fresh bits are needed before the next match. Overlap: every accepted bit in ARMED is checked.
- Reset or cfg_load mid-sequence: partial history is discarded; no match can use bits accepted before the event.
- match_count is readable every cycle and updates in the same cycle out rises.

Decomposition:
- Package fsm_pkg holds:
  - MODE_NONOVERLAP=1'b0 and MODE_OVERLAP=1'b1.
  - A clog2 helper function for sizing fill.
- One sub-module, sat_counter (parameter W; ports clk, rst, clr, inc, count). It is instantiated for match_count, with clr driven by cfg_load.
- The history register, fill counter and compare logic stay in seq_detector_param.

Test Plan:
- Defaults, non-overlap: after reset, in_valid=1 continuously, in=1,0,1,0,1,0 -> out=1 only in the cycle after the 4th bit; no pulse after the 6th bit; match_count=1.
- Overlap: cfg_load with cfg_pattern=4'b1010, cfg_overlap=1, then in=1,0,1,0,1,0 -> out pulses after the 4th and 6th bits; match_count=2.
- Valid gaps: in_valid pattern 1,0,1,0,1,1 carrying bits 1,x,0,x,1,0 -> single out pulse in the cycle after the last valid bit; out stays 0 during the gaps.
- Width and saturation, PAT_W=8, CNT_W=2:
  - cfg_pattern=8'hA5, overlap=0, stream 0,0,A5 bits -> one pulse; match_count=1.
  - Then cfg_pattern=8'hFF, overlap=1, twelve 1s -> out high from the 8th through the 12th bit cycle; match_count saturates at 3.
- Mid-operation interrupts:
  - Bits 1,0,1, then rst=1 for one cycle, then 0 -> no match; match_count=0.
  - Repeat with cfg_load in place of rst while in_valid=1 -> the bit in the load cycle is ignored and there is no match.

Source files
------------

// File: rtl/fsm_pkg.sv
// Shared constants and helpers for the serial pattern detectors.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package fsm_pkg;

    // Overlap mode encoding as carried on cfg_overlap.
    localparam logic MODE_NONOVERLAP = 1'b0;
    localparam logic MODE_OVERLAP    = 1'b1;

    // Ceiling log2, used at elaboration time to size counters.
    // clog2(n) is the number of bits needed to hold the values 0..n-1.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones, never wraps.
// Latency: count reflects inc/clr one cycle after the sampling edge.
// Backpressure: none; inc is accepted every cycle, clr has priority over inc.
//
// Ports:
//   clk   - rising-edge clock
//   rst   - synchronous active-high reset
//   clr   - synchronous clear to zero
//   inc   - increment request
//   count - current count value
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    localparam logic [W-1:0] CNT_MAX = {W{1'b1}};

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != CNT_MAX)) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/seq_detector_param.sv
// Parametrised serial bit-pattern detector with runtime pattern/overlap reload and saturating match count.
// Latency: out pulses in the cycle after the edge that sampled the final pattern bit (Moore timing).
// Backpressure: none; in is consumed whenever in_valid is high, cfg_load takes priority and drops that bit.
//
// Ports:
//   clk, rst              - clock and synchronous active-high reset
//   in_valid, in          - qualified serial input bit
//   cfg_load, cfg_pattern,
//   cfg_overlap           - one-cycle reload of pattern and overlap mode (clears history and count)
//   out                   - registered one-cycle match pulse
//   match_count           - saturating number of matches since reset/reload
module seq_detector_param
    import fsm_pkg::*;
#(
    parameter int               PAT_W       = 4,
    parameter logic [PAT_W-1:0] DEFAULT_PAT = PAT_W'(4'b1010),
    parameter int               CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             in,
    input  logic             cfg_load,
    input  logic [PAT_W-1:0] cfg_pattern,
    input  logic             cfg_overlap,
    output logic             out,
    output logic [CNT_W-1:0] match_count
);

    localparam int FILL_W = clog2(PAT_W + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);

    // Control state is a pure function of how many history bits are valid.
    localparam logic [1:0] ST_EMPTY   = 2'd0;
    localparam logic [1:0] ST_FILLING = 2'd1;
    localparam logic [1:0] ST_ARMED   = 2'd2;

    logic [PAT_W-1:0]  pat_q,  pat_d;
    logic              ovl_q,  ovl_d;
    logic [PAT_W-1:0]  hist_q, hist_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic              out_q,  out_d;

    logic [1:0]        state;
    logic [PAT_W-1:0]  hist_n;
    logic [FILL_W-1:0] fill_n;
    logic              match;
    logic              cnt_inc;

    always_comb begin
        if (fill_q == '0) begin
            state = ST_EMPTY;
        end else if (fill_q == FILL_FULL) begin
            state = ST_ARMED;
        end else begin
            state = ST_FILLING;
        end
    end

    // Candidate history/fill as if the current bit were accepted.
    // Once armed, fill saturates at PAT_W so every new bit is compared.
    always_comb begin
        hist_n = {hist_q[PAT_W-2:0], in};
        fill_n = (state == ST_ARMED) ? FILL_FULL : fill_q + FILL_W'(1);
        match  = (fill_n == FILL_FULL) && (hist_n == pat_q);
    end

    always_comb begin
        pat_d  = pat_q;
        ovl_d  = ovl_q;
        hist_d = hist_q;
        fill_d = fill_q;
        out_d  = 1'b0;
        if (cfg_load) begin
            // Reload discards any partial history; the bit on in this cycle is dropped.
            pat_d  = cfg_pattern;
            ovl_d  = cfg_overlap;
            hist_d = '0;
            fill_d = '0;
        end else if (in_valid) begin
            hist_d = hist_n;
            out_d  = match;
            if (match) begin
                // Non-overlap needs PAT_W fresh bits; overlap stays armed.
                fill_d = (ovl_q == MODE_OVERLAP) ? FILL_FULL : '0;
            end else begin
                fill_d = fill_n;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pat_q  <= DEFAULT_PAT;
            ovl_q  <= MODE_NONOVERLAP;
            hist_q <= '0;
            fill_q <= '0;
            out_q  <= 1'b0;
        end else begin
            pat_q  <= pat_d;
            ovl_q  <= ovl_d;
            hist_q <= hist_d;
            fill_q <= fill_d;
            out_q  <= out_d;
        end
    end

    assign cnt_inc = in_valid && !cfg_load && match;

    sat_counter #(
        .W (CNT_W)
    ) u_match_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (cfg_load),
        .inc   (cnt_inc),
        .count (match_count)
    );

    assign out = out_q;

endmodule

// File: tb/tb_seq_detector_param.sv
// Self-checking bench for seq_detector_param: a 4-bit default instance and an 8-bit/2-bit-count instance.
// Latency: expectations are aligned to the cycle after each driven bit.
// Backpressure: n/a.
module tb_seq_detector_param;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_bit;
    logic       cfg_load;
    logic [3:0] cfg_pattern4;
    logic [7:0] cfg_pattern8;
    logic       cfg_overlap;
    logic       out4;
    logic       out8;
    logic [7:0] cnt4;
    logic [1:0] cnt8;

    typedef struct {
        logic o;
        int   c;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    seq_detector_param #(
        .PAT_W       (4),
        .DEFAULT_PAT (4'b1010),
        .CNT_W       (8)
    ) u_dut4 (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in          (in_bit),
        .cfg_load    (cfg_load),
        .cfg_pattern (cfg_pattern4),
        .cfg_overlap (cfg_overlap),
        .out         (out4),
        .match_count (cnt4)
    );

    seq_detector_param #(
        .PAT_W       (8),
        .DEFAULT_PAT (8'hA5),
        .CNT_W       (2)
    ) u_dut8 (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in          (in_bit),
        .cfg_load    (cfg_load),
        .cfg_pattern (cfg_pattern8),
        .cfg_overlap (cfg_overlap),
        .out         (out8),
        .match_count (cnt8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply one input bit (or gap) and return just after the sampling edge.
    task automatic drive(input logic v, input logic b);
        @(negedge clk);
        in_valid = v;
        in_bit   = b;
        @(posedge clk);
        #1;
    endtask

    // One-cycle configuration strobe; in_valid/in_bit are driven alongside it.
    task automatic load(input logic [3:0] p4, input logic [7:0] p8, input logic ov,
                        input logic v, input logic b);
        @(negedge clk);
        cfg_load     = 1'b1;
        cfg_pattern4 = p4;
        cfg_pattern8 = p8;
        cfg_overlap  = ov;
        in_valid     = v;
        in_bit       = b;
        @(posedge clk);
        #1;
        cfg_load = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst      = 1'b1;
        in_valid = 1'b1;
        in_bit   = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (out4 !== 1'b0) $display("FAIL reset out4: got %b want 0", out4); else n_pass++;
        n_checks++;
        if (cnt4 !== 8'd0) $display("FAIL reset cnt4: got %0d want 0", cnt4); else n_pass++;
        n_checks++;
        if (out8 !== 1'b0) $display("FAIL reset out8: got %b want 0", out8); else n_pass++;
        n_checks++;
        if (cnt8 !== 2'd0) $display("FAIL reset cnt8: got %0d want 0", cnt8); else n_pass++;
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
    endtask

    task automatic test_nonoverlap();
        logic b[6]  = '{1, 0, 1, 0, 1, 0};
        logic eo[6] = '{0, 0, 0, 1, 0, 0};
        int   ec[6] = '{0, 0, 0, 1, 1, 1};
        exp_t t;
        for (int i = 0; i < 6; i++) begin
            t.o = eo[i];
            t.c = ec[i];
            sb.push_back(t);
            drive(1'b1, b[i]);
            t = sb.pop_front();
            n_checks++;
            if (out4 !== t.o) $display("FAIL nonoverlap out bit%0d: got %b want %b", i, out4, t.o); else n_pass++;
            n_checks++;
            if (int'(cnt4) !== t.c) $display("FAIL nonoverlap count bit%0d: got %0d want %0d", i, cnt4, t.c); else n_pass++;
        end
    endtask

    task automatic test_overlap();
        logic b[6]  = '{1, 0, 1, 0, 1, 0};
        logic eo[6] = '{0, 0, 0, 1, 0, 1};
        int   ec[6] = '{0, 0, 0, 1, 1, 2};
        exp_t t;
        load(4'b1010, 8'hA5, 1'b1, 1'b0, 1'b0);
        n_checks++;
        if (cnt4 !== 8'd0) $display("FAIL overlap load clears count: got %0d want 0", cnt4); else n_pass++;
        for (int i = 0; i < 6; i++) begin
            t.o = eo[i];
            t.c = ec[i];
            sb.push_back(t);
            drive(1'b1, b[i]);
            t = sb.pop_front();
            n_checks++;
            if (out4 !== t.o) $display("FAIL overlap out bit%0d: got %b want %b", i, out4, t.o); else n_pass++;
            n_checks++;
            if (int'(cnt4) !== t.c) $display("FAIL overlap count bit%0d: got %0d want %0d", i, cnt4, t.c); else n_pass++;
        end
    endtask

    task automatic test_valid_gaps();
        // Gap cycles carry 1s that would break the pattern if accepted.
        logic v[6]  = '{1, 0, 1, 0, 1, 1};
        logic b[6]  = '{1, 1, 0, 1, 1, 0};
        logic eo[6] = '{0, 0, 0, 0, 0, 1};
        int   ec[6] = '{0, 0, 0, 0, 0, 1};
        exp_t t;
        load(4'b1010, 8'hA5, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            t.o = eo[i];
            t.c = ec[i];
            sb.push_back(t);
            drive(v[i], b[i]);
            t = sb.pop_front();
            n_checks++;
            if (out4 !== t.o) $display("FAIL gaps out cyc%0d: got %b want %b", i, out4, t.o); else n_pass++;
            n_checks++;
            if (int'(cnt4) !== t.c) $display("FAIL gaps count cyc%0d: got %0d want %0d", i, cnt4, t.c); else n_pass++;
        end
    endtask

    task automatic test_width_sat();
        logic [9:0] stream = 10'b00_1010_0101;
        exp_t t;
        load(4'b0000, 8'hA5, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            t.o = (i == 9);
            t.c = (i == 9) ? 1 : 0;
            sb.push_back(t);
            drive(1'b1, stream[9 - i]);
            t = sb.pop_front();
            n_checks++;
            if (out8 !== t.o) $display("FAIL wide A5 out bit%0d: got %b want %b", i, out8, t.o); else n_pass++;
            n_checks++;
            if (int'(cnt8) !== t.c) $display("FAIL wide A5 count bit%0d: got %0d want %0d", i, cnt8, t.c); else n_pass++;
        end
        load(4'b0000, 8'hFF, 1'b1, 1'b0, 1'b0);
        for (int i = 1; i <= 12; i++) begin
            t.o = (i >= 8);
            t.c = (i < 8) ? 0 : ((i - 7 > 3) ? 3 : i - 7);
            sb.push_back(t);
            drive(1'b1, 1'b1);
            t = sb.pop_front();
            n_checks++;
            if (out8 !== t.o) $display("FAIL ones out bit%0d: got %b want %b", i, out8, t.o); else n_pass++;
            n_checks++;
            if (int'(cnt8) !== t.c) $display("FAIL ones saturate bit%0d: got %0d want %0d", i, cnt8, t.c); else n_pass++;
        end
    endtask

    task automatic test_rst_interrupt();
        logic b[3] = '{1, 0, 1};
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) drive(1'b1, b[i]);
        // Reset with a would-complete bit on the input.
        @(negedge clk);
        rst      = 1'b1;
        in_valid = 1'b1;
        in_bit   = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        n_checks++;
        if (out4 !== 1'b0) $display("FAIL rst mid out: got %b want 0", out4); else n_pass++;
        drive(1'b1, 1'b0);
        n_checks++;
        if (out4 !== 1'b0) $display("FAIL rst after out: got %b want 0", out4); else n_pass++;
        n_checks++;
        if (cnt4 !== 8'd0) $display("FAIL rst after count: got %0d want 0", cnt4); else n_pass++;
    endtask

    task automatic test_cfg_interrupt();
        logic b[3]  = '{1, 0, 1};
        logic b2[5] = '{0, 1, 0, 1, 0};
        exp_t t;
        load(4'b1010, 8'hA5, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) drive(1'b1, b[i]);
        // The 0 offered during the load would complete 1010 if it were accepted.
        load(4'b1010, 8'hA5, 1'b0, 1'b1, 1'b0);
        n_checks++;
        if (out4 !== 1'b0) $display("FAIL cfg mid out: got %b want 0", out4); else n_pass++;
        for (int i = 0; i < 5; i++) begin
            t.o = (i == 4);
            t.c = (i == 4) ? 1 : 0;
            sb.push_back(t);
            drive(1'b1, b2[i]);
            t = sb.pop_front();
            n_checks++;
            if (out4 !== t.o) $display("FAIL cfg after out bit%0d: got %b want %b", i, out4, t.o); else n_pass++;
            n_checks++;
            if (int'(cnt4) !== t.c) $display("FAIL cfg after count bit%0d: got %0d want %0d", i, cnt4, t.c); else n_pass++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst          = 1'b1;
        in_valid     = 1'b0;
        in_bit       = 1'b0;
        cfg_load     = 1'b0;
        cfg_pattern4 = 4'b0000;
        cfg_pattern8 = 8'h00;
        cfg_overlap  = 1'b0;
        test_reset();
        test_nonoverlap();
        test_overlap();
        test_valid_gaps();
        test_width_sat();
        test_rst_interrupt();
        test_cfg_interrupt();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
